// File: rtl/sdpram_arb_pkg.sv
// Shared definitions for the simple-dual-port RAM arbiter.
//   state_t : controller state (clear sweep / normal run)
//   NUM_REQ : number of requesters sharing the RAM
package sdpram_arb_pkg;
    localparam int NUM_REQ = 2;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter with a favoured-requester pointer.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_en           : grants allowed this cycle
//   i_req          : eligible requesters
//   o_gnt          : one-hot grant (combinational)
// The pointer names the requester that wins a tie; after any grant it
// moves to the other requester. A lone requester always wins.
module rr_arb2 (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_en,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);
    logic r_prio;

    always_comb begin
        o_gnt = 2'b00;
        if (i_en) begin
            if (i_req == 2'b11) o_gnt = r_prio ? 2'b10 : 2'b01;
            else                o_gnt = i_req;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)   r_prio <= 1'b0;
        else if (|o_gnt) r_prio <= o_gnt[0];
    end
endmodule

// File: rtl/sdpram_arbiter.sv
// Arbiter in front of a simple-dual-port RAM (one write port, one read
// port, registered read data with 1-cycle latency). After reset or a
// clear request the whole RAM is swept with CLEAR_VALUE before normal
// operation; in RUN each port is round-robin arbitrated independently.
//   clk, reset_n          : clock, async active-low reset
//   clear_req             : start a full clear (honoured in RUN only)
//   ready                 : high in RUN
//   req/we/addrN/wdataN   : requester ops (we=1 write, 0 read)
//   ack                   : combinational accept per requester
//   rvalid/rdata          : read return, 2 cycles after ack
//   ram_wr_* / ram_rd_addr: registered RAM controls
//   ram_rd_data           : RAM read output
import sdpram_arb_pkg::*;

module sdpram_arbiter #(
    parameter int                 ADDR_W      = 8,
    parameter int                 DATA_W      = 8,
    parameter logic [DATA_W-1:0]  CLEAR_VALUE = '0,
    parameter logic [ADDR_W-1:0]  PARK_ADDR   = {ADDR_W{1'b1}}
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clear_req,
    output logic                ready,
    input  logic [NUM_REQ-1:0]  req,
    input  logic [NUM_REQ-1:0]  we,
    input  logic [ADDR_W-1:0]   addr0,
    input  logic [ADDR_W-1:0]   addr1,
    input  logic [DATA_W-1:0]   wdata0,
    input  logic [DATA_W-1:0]   wdata1,
    output logic [NUM_REQ-1:0]  ack,
    output logic [NUM_REQ-1:0]  rvalid,
    output logic [DATA_W-1:0]   rdata,
    output logic                ram_wr_en,
    output logic [ADDR_W-1:0]   ram_wr_addr,
    output logic [DATA_W-1:0]   ram_wr_data,
    output logic [ADDR_W-1:0]   ram_rd_addr,
    input  logic [DATA_W-1:0]   ram_rd_data
);
    state_t                      r_state, w_state_nxt;
    logic [ADDR_W-1:0]           r_cnt, w_cnt_nxt;
    logic                        w_run;
    logic [NUM_REQ-1:0]          w_wr_gnt, w_rd_gnt;
    // read-valid shift register: [0] = addr issued, [1] = data returned
    logic [1:0][NUM_REQ-1:0]     r_rv_pipe;

    assign w_run = (r_state == ST_RUN);
    assign ready = w_run;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_CLEAR: begin
                // counter wraps to 0 on the last address, ready for next clear
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == {ADDR_W{1'b1}}) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (clear_req) begin
                    w_state_nxt = ST_CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_CLEAR;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    rr_arb2 u_wr_arb (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_en    (w_run),
        .i_req   (req & we),
        .o_gnt   (w_wr_gnt)
    );

    rr_arb2 u_rd_arb (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_en    (w_run),
        .i_req   (req & ~we),
        .o_gnt   (w_rd_gnt)
    );

    // a requester is either a writer or a reader, never both
    assign ack = w_wr_gnt | w_rd_gnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ram_wr_en   <= 1'b0;
            ram_wr_addr <= PARK_ADDR;
            ram_wr_data <= CLEAR_VALUE;
            ram_rd_addr <= '0;
            r_rv_pipe   <= '0;
        end else begin
            if (!w_run) begin
                ram_wr_en   <= 1'b1;
                ram_wr_addr <= r_cnt;
                ram_wr_data <= CLEAR_VALUE;
            end else if (|w_wr_gnt) begin
                ram_wr_en   <= 1'b1;
                ram_wr_addr <= w_wr_gnt[1] ? addr1  : addr0;
                ram_wr_data <= w_wr_gnt[1] ? wdata1 : wdata0;
            end else begin
                // idle write port parks on one harmless address
                ram_wr_en   <= 1'b0;
                ram_wr_addr <= PARK_ADDR;
                ram_wr_data <= CLEAR_VALUE;
            end
            if (|w_rd_gnt) ram_rd_addr <= w_rd_gnt[1] ? addr1 : addr0;
            // in-flight reads keep flowing through a clear
            r_rv_pipe <= {r_rv_pipe[0], w_rd_gnt};
        end
    end

    assign rvalid = r_rv_pipe[1];
    assign rdata  = ram_rd_data;
endmodule

// File: tb/tb_sdpram_arbiter.sv
module tb_sdpram_arbiter;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       clear_req;
    logic [1:0] req, we;
    logic [7:0] addr0, addr1, wdata0, wdata1;
    logic       ready, ram_wr_en;
    logic [1:0] ack, rvalid;
    logic [7:0] rdata, ram_wr_addr, ram_wr_data, ram_rd_addr;
    logic [7:0] ram_rd_data;
    logic [7:0] mem [256];

    // small instance (ADDR_W=4) used for the clear sweep check
    logic       s_ready, s_wen;
    logic [1:0] s_ack, s_rvalid;
    logic [7:0] s_rdata, s_wdata;
    logic [3:0] s_waddr, s_raddr;

    int total = 0;
    int bad   = 0;
    int cyc;

    always #5 clk = ~clk;

    sdpram_arbiter u_dut (
        .clk(clk), .reset_n(reset_n), .clear_req(clear_req), .ready(ready),
        .req(req), .we(we), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1), .ack(ack), .rvalid(rvalid),
        .rdata(rdata), .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr),
        .ram_wr_data(ram_wr_data), .ram_rd_addr(ram_rd_addr),
        .ram_rd_data(ram_rd_data)
    );

    sdpram_arbiter #(.ADDR_W(4)) u_small (
        .clk(clk), .reset_n(reset_n), .clear_req(1'b0), .ready(s_ready),
        .req(2'b00), .we(2'b00), .addr0(4'h0), .addr1(4'h0),
        .wdata0(8'h00), .wdata1(8'h00), .ack(s_ack), .rvalid(s_rvalid),
        .rdata(s_rdata), .ram_wr_en(s_wen), .ram_wr_addr(s_waddr),
        .ram_wr_data(s_wdata), .ram_rd_addr(s_raddr),
        .ram_rd_data(8'h00)
    );

    // read-first RAM: same-edge read returns the old word
    always @(posedge clk) begin
        ram_rd_data <= mem[ram_rd_addr];
        if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] ex);
        total++;
        assert (obs === ex) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, ex);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // directed table for continuous two-requester reads
    logic [1:0] t_ack [6] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00};
    logic [1:0] t_rv  [6] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b01, 2'b10};
    logic [7:0] t_rd  [6] = '{8'h00, 8'h00, 8'hA5, 8'h5A, 8'hA5, 8'h5A};
    logic [7:0] t_ra  [6] = '{8'h10, 8'h03, 8'h10, 8'h03, 8'h10, 8'h10};

    initial begin
        reset_n = 1'b0; clear_req = 1'b0; req = 2'b00; we = 2'b00;
        addr0 = 8'h00; addr1 = 8'h00; wdata0 = 8'h00; wdata1 = 8'h00;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_ready",  ready,       0);
        chk("rst_wen",    ram_wr_en,   0);
        chk("rst_waddr",  ram_wr_addr, 8'hFF);
        chk("rst_wdata",  ram_wr_data, 8'h00);
        chk("rst_raddr",  ram_rd_addr, 8'h00);
        chk("rst_rvalid", rvalid,      0);
        chk("rst_s_waddr", s_waddr,    4'hF);

        // clear sweep after reset release; requests must be ignored
        req = 2'b11; we = 2'b00; reset_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk("s_clr_en",   s_wen,   1);
            chk("s_clr_addr", s_waddr, k - 1);
            chk("s_clr_data", s_wdata, 8'h00);
            chk("s_ready",    s_ready, k == 16);
            #1 chk("clr_ack", ack, 2'b00);
        end
        req = 2'b00;
        cyc = 16;
        while (!ready && cyc < 400) begin
            tick();
            cyc++;
        end
        chk("clr_len", cyc, 256);
        chk("clr_mem", mem[8'h10], 8'h00);

        // write by req0 and read by req1 in the same cycle
        req = 2'b11; we = 2'b01; addr0 = 8'h03; wdata0 = 8'hA5; addr1 = 8'h07;
        #1 chk("wr_rd_ack", ack, 2'b11);
        tick();
        chk("wr_en",   ram_wr_en,   1);
        chk("wr_addr", ram_wr_addr, 8'h03);
        chk("wr_data", ram_wr_data, 8'hA5);
        chk("rd_addr", ram_rd_addr, 8'h07);
        req = 2'b00;
        #1 chk("idle_ack", ack, 2'b00);
        tick();
        chk("park_en",   ram_wr_en,   0);
        chk("park_addr", ram_wr_addr, 8'hFF);
        chk("park_data", ram_wr_data, 8'h00);
        chk("rv_a",      rvalid,      2'b10);
        chk("rd_a",      rdata,       8'h00);

        // same-cycle write/read returns old data, next-cycle read returns new
        req = 2'b11; we = 2'b01; addr0 = 8'h10; wdata0 = 8'h5A; addr1 = 8'h10;
        #1 chk("raw_ack0", ack, 2'b11);
        tick();
        chk("raw_wen",   ram_wr_en,   1);
        chk("raw_waddr", ram_wr_addr, 8'h10);
        chk("raw_wdata", ram_wr_data, 8'h5A);
        req = 2'b10; we = 2'b00;
        #1 chk("raw_ack1", ack, 2'b10);
        tick();
        req = 2'b00;
        chk("raw_rv0", rvalid, 2'b10);
        chk("raw_old", rdata,  8'h00);
        tick();
        chk("raw_rv1", rvalid, 2'b10);
        chk("raw_new", rdata,  8'h5A);
        tick();
        chk("raw_rv2", rvalid, 2'b00);

        // write-port round robin: pointer favours req1 after req0 won
        req = 2'b11; we = 2'b11; addr0 = 8'h20; wdata0 = 8'h11; addr1 = 8'h21; wdata1 = 8'h22;
        #1 chk("wrr_ack0", ack, 2'b10);
        tick();
        chk("wrr_addr0", ram_wr_addr, 8'h21);
        chk("wrr_data0", ram_wr_data, 8'h22);
        #1 chk("wrr_ack1", ack, 2'b01);
        tick();
        chk("wrr_addr1", ram_wr_addr, 8'h20);
        chk("wrr_data1", ram_wr_data, 8'h11);
        chk("wrr_raddr", ram_rd_addr, 8'h10);
        req = 2'b00;
        tick();

        // both requesters read continuously
        we = 2'b00; addr0 = 8'h03; addr1 = 8'h10;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick();
            chk("rr_rv",    rvalid,      t_rv[i]);
            if (t_rv[i] != 2'b00) chk("rr_rdata", rdata, t_rd[i]);
            chk("rr_raddr", ram_rd_addr, t_ra[i]);
            req = (i < 4) ? 2'b11 : 2'b00;
            #1 chk("rr_ack", ack, t_ack[i]);
        end
        tick();

        // clear request with a read in flight
        req = 2'b01; we = 2'b00; addr0 = 8'h03;
        #1 chk("clr_rd_ack", ack, 2'b01);
        tick();
        req = 2'b00; clear_req = 1'b1;
        chk("clr_ready_pre", ready, 1);
        tick();
        clear_req = 1'b0;
        chk("clr_rv", rvalid, 2'b01);
        req = 2'b11;
        for (int k = 0; k < 256; k++) begin
            if (k > 0) tick();
            clear_req = (k == 100);
            chk("clr2_ready", ready, 0);
            #1 chk("clr2_ack", ack, 2'b00);
        end
        req = 2'b00; clear_req = 1'b0;
        tick();
        chk("clr2_done", ready, 1);

        // reset one cycle after a read ack drops the read
        req = 2'b01; addr0 = 8'h03;
        #1 chk("rst_rd_ack", ack, 2'b01);
        tick();
        req = 2'b00; reset_n = 1'b0;
        #1;
        chk("arst_rv",    rvalid,      0);
        chk("arst_ready", ready,       0);
        chk("arst_waddr", ram_wr_addr, 8'hFF);
        tick();
        chk("arst_rv2", rvalid, 0);
        reset_n = 1'b1;
        tick();
        chk("rclr_en",    ram_wr_en,   1);
        chk("rclr_addr0", ram_wr_addr, 8'h00);
        chk("rclr_rv",    rvalid,      0);
        tick();
        chk("rclr_addr1", ram_wr_addr, 8'h01);
        chk("rclr_rv2",   rvalid,      0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
